// File: rtl/universal_shift_reg.sv
// N-bit universal shift register: parallel load, shift/rotate in both directions,
// synchronous clear, and a shift counter that pulses Done on every WIDTH-th shift.
module universal_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             CW        = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic             SerOut,
    output logic [CW-1:0]    ShiftCnt,
    output logic             Done
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mode_t mode;
    logic  shifting;

    assign mode     = mode_t'(Mode);
    // Only the four shift/rotate codes advance the counter; load/clear reset it instead.
    assign shifting = En && (mode == MODE_SHL || mode == MODE_SHR ||
                             mode == MODE_ROL || mode == MODE_ROR);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Q        <= RESET_VAL;
            SerOut   <= 1'b0;
            ShiftCnt <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (En) begin
                case (mode)
                    MODE_LOAD: begin
                        Q        <= D;
                        ShiftCnt <= '0;
                    end
                    MODE_SHL: begin
                        Q      <= {Q[WIDTH-2:0], SerIn};
                        SerOut <= Q[WIDTH-1];
                    end
                    MODE_SHR: begin
                        Q      <= {SerIn, Q[WIDTH-1:1]};
                        SerOut <= Q[0];
                    end
                    MODE_ROL: begin
                        Q      <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                        SerOut <= Q[WIDTH-1];
                    end
                    MODE_ROR: begin
                        Q      <= {Q[0], Q[WIDTH-1:1]};
                        SerOut <= Q[0];
                    end
                    MODE_CLEAR: begin
                        Q        <= '0;
                        SerOut   <= 1'b0;
                        ShiftCnt <= '0;
                    end
                    default: ;
                endcase
            end
            if (shifting) begin
                if (ShiftCnt == CNT_LAST) begin
                    ShiftCnt <= '0;
                    Done     <= 1'b1;
                end else begin
                    ShiftCnt <= ShiftCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed-vector bench for universal_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             En = 1'b0;
    logic [2:0]       Mode = 3'b000;
    logic [WIDTH-1:0] D = '0;
    logic             SerIn = 1'b0;
    logic [WIDTH-1:0] Q;
    logic             SerOut;
    logic [CW-1:0]    ShiftCnt;
    logic             Done;

    int checks = 0;
    int failures = 0;

    universal_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'hA5)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .D(D), .SerIn(SerIn),
        .Q(Q), .SerOut(SerOut), .ShiftCnt(ShiftCnt), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] q, input logic so,
                           input logic [CW-1:0] cnt, input logic dn);
        chk({tag, ".Q"}, 32'(Q), 32'(q));
        chk({tag, ".SerOut"}, 32'(SerOut), 32'(so));
        chk({tag, ".ShiftCnt"}, 32'(ShiftCnt), 32'(cnt));
        chk({tag, ".Done"}, 32'(Done), 32'(dn));
    endtask

    initial begin
        logic [7:0] so_exp;
        logic [7:0] pat;
        logic [7:0] shl_q [5];

        // Async reset asserted while Clk is low, checked before the next edge
        #2 Reset = 1'b1;
        #1 chk_all("rst_async", 8'hA5, 1'b0, '0, 1'b0);
        cyc();
        chk_all("rst_hold", 8'hA5, 1'b0, '0, 1'b0);
        @(negedge Clk) Reset = 1'b0;
        cyc();
        chk_all("rst_release", 8'hA5, 1'b0, '0, 1'b0);

        // Load 81 then shift left 8x with SerIn=0
        En = 1'b1; Mode = 3'b001; D = 8'h81;
        cyc();
        chk_all("load81", 8'h81, 1'b0, '0, 1'b0);
        Mode = 3'b010; SerIn = 1'b0;
        so_exp = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("shl%0d.SerOut", i), 32'(SerOut), 32'(so_exp[7-i]));
            chk($sformatf("shl%0d.Done", i), 32'(Done), (i == 7) ? 32'd1 : 32'd0);
            chk($sformatf("shl%0d.Cnt", i), 32'(ShiftCnt), (i == 7) ? 32'd0 : 32'(i + 1));
        end
        chk("shl_final.Q", 32'(Q), 32'h00);
        Mode = 3'b000;
        cyc();
        chk_all("hold_after_wrap", 8'h00, 1'b1, '0, 1'b0);

        // Rotate right then left
        Mode = 3'b001; D = 8'h01;
        cyc();
        Mode = 3'b101;
        cyc();
        chk_all("ror", 8'h80, 1'b1, CW'(1), 1'b0);
        Mode = 3'b100;
        cyc();
        chk_all("rol", 8'h01, 1'b1, CW'(2), 1'b0);

        // Shift right 8x from 00 with serial pattern
        Mode = 3'b001; D = 8'h00;
        cyc();
        Mode = 3'b011;
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            SerIn = pat[i];
            cyc();
            chk($sformatf("shr%0d.Done", i), 32'(Done), (i == 7) ? 32'd1 : 32'd0);
        end
        chk_all("shr_final", 8'h4D, 1'b0, '0, 1'b1);

        // Shift 5x, freeze with En=0, then load FF
        Mode = 3'b010; SerIn = 1'b1;
        shl_q = '{8'h9B, 8'h37, 8'h6F, 8'hDF, 8'hBF};
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("shl5_%0d.Q", i), 32'(Q), 32'(shl_q[i]));
        end
        chk_all("shl5", 8'hBF, 1'b1, CW'(5), 1'b0);
        En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_all($sformatf("freeze%0d", i), 8'hBF, 1'b1, CW'(5), 1'b0);
        end
        En = 1'b1; Mode = 3'b001; D = 8'hFF;
        cyc();
        chk_all("loadFF", 8'hFF, 1'b1, '0, 1'b0);
        Mode = 3'b111;
        cyc();
        chk_all("reserved", 8'hFF, 1'b1, '0, 1'b0);

        // Load on the cycle that would have wrapped: load wins, no Done
        Mode = 3'b100;
        for (int i = 0; i < 7; i++) cyc();
        chk("rol7.Cnt", 32'(ShiftCnt), 32'd7);
        Mode = 3'b001; D = 8'h5A;
        cyc();
        chk_all("load_at_wrap", 8'h5A, 1'b1, '0, 1'b0);

        // Clear after load 3C
        D = 8'h3C;
        cyc();
        Mode = 3'b110;
        cyc();
        chk_all("clear", 8'h00, 1'b0, '0, 1'b0);

        // Reset during a shift sequence at count 6
        Mode = 3'b010; SerIn = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk_all("pre_reset", 8'h3F, 1'b0, CW'(6), 1'b0);
        #3 Reset = 1'b1;
        #1 chk_all("rst_mid_shift", 8'hA5, 1'b0, '0, 1'b0);
        cyc();
        chk_all("rst_mid_hold", 8'hA5, 1'b0, '0, 1'b0);
        @(negedge Clk) begin
            Reset = 1'b0;
            En = 1'b0;
        end
        cyc();
        chk_all("rst_mid_release", 8'hA5, 1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
